// File: rtl/sram_like_slave.sv
// Responder for the sram-like req/addr_ok/data_ok bus: an in-order request queue in front of
// a word-addressed RAM. Each head entry is answered after LATENCY unstalled cycles.
module sram_like_slave #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1,
  parameter int MEM_AW  = 12
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  input  logic        resp_stall_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic              wr;
    logic [3:0]        wstrb;
    logic [MEM_AW-1:0] idx;
    logic [31:0]       wdata;
  } ent_t;

  ent_t              q_mem [DEPTH];
  logic [31:0]       mem_q [2**MEM_AW];

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              dok_q, dok_d;
  logic [31:0]       rdata_q, rdata_d;

  ent_t              head_e, push_e;
  logic              push, pop, empty;

  // Size and the sub-word / out-of-range address bits carry no meaning for this RAM.
  logic unused_ok;
  assign unused_ok = ^{size_i, addr_i[31:MEM_AW+2], addr_i[1:0]};

  assign addr_ok_o = !reset_i && (count_q != CW'(DEPTH));
  assign data_ok_o = dok_q;
  assign rdata_o   = rdata_q;

  always_comb begin
    empty   = (count_q == '0);
    push    = req_i && addr_ok_o;
    push_e  = '{wr: wr_i, wstrb: wstrb_i, idx: addr_i[MEM_AW+1:2], wdata: wdata_i};
    head_e  = q_mem[head_q];
    pop     = !reset_i && !empty && (cnt_q == LW'(LATENCY - 1)) && !resp_stall_i;

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // A fresh head always starts its wait from zero; a stalled head keeps its progress.
    cnt_d = cnt_q;
    if ((push && empty) || (pop && count_d != '0)) cnt_d = '0;
    else if (!empty && !resp_stall_i)               cnt_d = cnt_q + LW'(1);

    dok_d   = pop;
    rdata_d = rdata_q;
    if (pop) rdata_d = head_e.wr ? 32'h0 : mem_q[head_e.idx];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      dok_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      dok_q   <= dok_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) q_mem[tail_q] <= push_e;
  end

  // Writes commit when they leave the queue, so ordering against later reads is preserved.
  always_ff @(posedge clk_i) begin
    if (pop && head_e.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (head_e.wstrb[i]) mem_q[head_e.idx][8*i +: 8] <= head_e.wdata[8*i +: 8];
      end
    end
  end

endmodule
